// File: rtl/msg_uart_tx.sv
// msg_uart_tx: transmits a fixed, parameter-defined message as 8N1-style UART
// frames (LSB first), launched by a rising edge on an asynchronous start input.
// An optional even-parity bit is built in when MSG_UART_TX_PARITY_EN is defined.
// Optional idle gap between bytes; repeat mode restarts the message without idling.
module msg_uart_tx #(
    parameter int                   CLK_DIV   = 434,
    parameter int                   MSG_LEN   = 17,
    parameter logic [8*MSG_LEN-1:0] MSG_DATA  = 136'h69206C696B65207665726C6F6720746F6F,
    parameter int                   STOP_BITS = 1,
    parameter int                   GAP_BITS  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       repeat_en,
    input  logic       abort,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [5:0] byte_idx
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef MSG_UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_t;

    state_t      state, state_n;
    logic        sync1, sync2, edge_reg;
    logic        start_edge;
    logic [15:0] baud;
    logic        bit_end;
    logic [2:0]  bit_cnt;
    logic        stop_cnt;
    logic [7:0]  gap_cnt;
    logic [7:0]  shreg;
    logic        load;
    logic        eob;
    logic        stop_last;
    logic [5:0]  idx_n;
`ifdef MSG_UART_TX_PARITY_EN
    logic        par;
`endif

    // Byte k of the message; byte 0 is the most-significant byte.
    function automatic logic [7:0] msg_byte(input logic [5:0] k);
        int base;
        base = 8 * (MSG_LEN - int'(k)) - 1;
        return MSG_DATA[base -: 8];
    endfunction

    assign start_edge = sync2 & ~edge_reg;
    assign bit_end    = (baud == 16'd0);
    assign stop_last  = (STOP_BITS == 1) || stop_cnt;
    assign busy       = (state != IDLE);

    // Synchronize the asynchronous start level and keep the previous value for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            sync1    <= start;
            sync2    <= sync1;
            edge_reg <= sync2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next-state logic; abort overrides everything, including the done pulse.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        idx_n   = byte_idx;
        done    = 1'b0;
        eob     = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge && !abort) begin
                    state_n = START;
                    load    = 1'b1;
                    idx_n   = 6'd0;
                end
            end
            START: if (bit_end) state_n = DATA;
            DATA: begin
                if (bit_end && bit_cnt == 3'd7) begin
`ifdef MSG_UART_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef MSG_UART_TX_PARITY_EN
            PARITY: if (bit_end) state_n = STOP;
`endif
            STOP: begin
                if (bit_end && stop_last) begin
                    if (GAP_BITS > 0) state_n = GAP;
                    else              eob     = 1'b1;
                end
            end
            GAP: if (bit_end && gap_cnt == 8'(GAP_BITS - 1)) eob = 1'b1;
            default: state_n = IDLE;
        endcase
        if (eob) begin
            if (byte_idx == 6'(MSG_LEN - 1)) begin
                done = 1'b1;
                if (repeat_en) begin
                    state_n = START;
                    load    = 1'b1;
                    idx_n   = 6'd0;
                end else begin
                    state_n = IDLE;
                end
            end else begin
                state_n = START;
                load    = 1'b1;
                idx_n   = byte_idx + 6'd1;
            end
        end
        if (abort && state != IDLE) begin
            state_n = IDLE;
            load    = 1'b0;
            done    = 1'b0;
        end
    end

    // Bit timing, counters, shift register and byte index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud     <= 16'd0;
            bit_cnt  <= 3'd0;
            stop_cnt <= 1'b0;
            gap_cnt  <= 8'd0;
            shreg    <= 8'd0;
            byte_idx <= 6'd0;
`ifdef MSG_UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            if (state_n == IDLE)                          baud <= 16'd0;
            else if (state_n != state || bit_end || load) baud <= 16'(CLK_DIV - 1);
            else                                          baud <= baud - 16'd1;

            bit_cnt  <= (state == DATA) ? bit_cnt + 3'(bit_end) : 3'd0;
            stop_cnt <= (state == STOP) ? stop_cnt ^ bit_end    : 1'b0;
            gap_cnt  <= (state == GAP)  ? gap_cnt + 8'(bit_end) : 8'd0;

            if (load) begin
                shreg <= msg_byte(idx_n);
`ifdef MSG_UART_TX_PARITY_EN
                par   <= ^msg_byte(idx_n);
`endif
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
            end

            if (state_n == IDLE) byte_idx <= 6'd0;
            else if (load)       byte_idx <= idx_n;
        end
    end

    // Line level follows the current bit state; idle and stop/gap are high.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:  tx = 1'b0;
            DATA:   tx = shreg[0];
`ifdef MSG_UART_TX_PARITY_EN
            PARITY: tx = par;
`endif
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_msg_uart_tx.sv
// Scoreboard bench for msg_uart_tx: frame decoder on DUT a (CLK_DIV=4, 2-byte
// message, no gap), repeat/gap checks on DUT b (GAP_BITS=2).
module tb_msg_uart_tx;
    localparam int CD = 4;
    localparam int ML = 2;
    localparam logic [15:0] MD = 16'h4155;
`ifdef MSG_UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB = 10 + PB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, rep_a, abort_a, tx_a, busy_a, done_a;
    logic [5:0] idx_a;
    logic       start_b, rep_b, abort_b, tx_b, busy_b, done_b;
    logic [5:0] idx_b;

    msg_uart_tx #(.CLK_DIV(CD), .MSG_LEN(ML), .MSG_DATA(MD), .STOP_BITS(1), .GAP_BITS(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .repeat_en(rep_a), .abort(abort_a),
        .tx(tx_a), .busy(busy_a), .done(done_a), .byte_idx(idx_a));

    msg_uart_tx #(.CLK_DIV(CD), .MSG_LEN(ML), .MSG_DATA(MD), .STOP_BITS(1), .GAP_BITS(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .repeat_en(rep_b), .abort(abort_b),
        .tx(tx_b), .busy(busy_b), .done(done_b), .byte_idx(idx_b));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         idx;
    } exp_t;
    exp_t sb[$];

    bit mon_en = 1'b0;
    int done_cnt_a = 0;

    task automatic push_msg();
        logic [15:0] md;
        exp_t e;
        md = MD;
        for (int k = 0; k < ML; k++) begin
            e.data = md[8*(ML-k)-1 -: 8];
            e.idx  = k;
            sb.push_back(e);
        end
    endtask

    // Decode one frame starting at the current (first start-bit) sample.
    task automatic decode_frame();
        logic [FB-1:0] bits;
        logic [5:0]    idx0;
        logic          d_last;
        bit            stable;
        exp_t          e;
        stable = 1'b1;
        idx0   = idx_a;
        bits   = '0;
        for (int b = 0; b < FB; b++) begin
            for (int c = 0; c < CD; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (c == 0) bits[b] = tx_a;
                else if (tx_a !== bits[b]) stable = 1'b0;
                if (idx_a !== idx0) stable = 1'b0;
                if (!(b == FB-1 && c == CD-1) && done_a === 1'b1) stable = 1'b0;
            end
        end
        d_last = done_a;
        if (sb.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("frame_stable", 32'(stable), 32'd1);
            chk("start_bit", 32'(bits[0]), 32'd0);
            chk("data", 32'(bits[8:1]), 32'(e.data));
`ifdef MSG_UART_TX_PARITY_EN
            chk("parity", 32'(bits[9]), 32'(^e.data));
`endif
            chk("stop_bit", 32'(bits[FB-1]), 32'd1);
            chk("byte_idx", 32'(idx0), 32'(e.idx));
            chk("done_at_end", 32'(d_last), 32'(e.idx == ML-1));
        end
    endtask

    // Frame monitor for DUT a.
    always @(negedge clk) if (mon_en && rst === 1'b1 && tx_a === 1'b0) decode_frame();

    // Count done pulses of DUT a.
    always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        repeat (2) @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int max);
        int n;
        n = 0;
        while (busy_a !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout_a", 32'(busy_a), 32'd0);
    endtask

    initial begin
        int n, cyc, d0, lows, run, started, dones, last_done, busy_low;
        rst = 1'b0;
        start_a = 0; rep_a = 0; abort_a = 0;
        start_b = 0; rep_b = 0; abort_b = 0;
        #3;
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_idx", 32'(idx_a), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Latency, full stream, ignored mid-message start, back-to-back relaunch.
        mon_en = 1'b1;
        push_msg();
        start_a = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (tx_a !== 1'b0 && n < 10);
        chk("start_latency", 32'(n), 32'd3);
        cyc = 0;
        do begin
            @(negedge clk); cyc++;
            if (cyc == 2)  start_a = 1'b0;
            if (cyc == 40) start_a = 1'b1;
            if (cyc == 42) start_a = 1'b0;
            if (cyc == 79) begin push_msg(); start_a = 1'b1; end
        end while (done_a !== 1'b1 && cyc < 200);
        chk("done_cycle", 32'(cyc), 32'(ML*FB*CD));
        @(negedge clk);
        chk("busy_drop", 32'(busy_a), 32'd0);
        @(negedge clk);
        chk("back_to_back", 32'(busy_a), 32'd1);
        start_a = 1'b0;
        wait_idle_a(200);
        repeat (30) @(negedge clk);
        chk("sb_empty_1", 32'(sb.size()), 32'd0);
        chk("done_count_1", 32'(done_cnt_a), 32'd2);

        // Abort mid DATA of byte 1, then abort coinciding with a start edge in IDLE.
        mon_en = 1'b0;
        pulse_start_a();
        n = 0;
        while (idx_a !== 6'd1 && n < 200) begin @(negedge clk); n++; end
        chk("reach_byte1", 32'(idx_a), 32'd1);
        repeat (10) @(negedge clk);
        d0 = done_cnt_a;
        abort_a = 1'b1;
        @(posedge clk); #1;
        chk("abort_tx", 32'(tx_a), 32'd1);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_idx", 32'(idx_a), 32'd0);
        @(negedge clk);
        start_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_start_idle", 32'(busy_a), 32'd0);
        start_a = 1'b0;
        abort_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt_a), 32'(d0));
        chk("abort_stays_idle", 32'(busy_a), 32'd0);
        mon_en = 1'b1;
        push_msg();
        pulse_start_a();
        n = 0;
        while (done_cnt_a == d0 && n < 300) begin @(negedge clk); n++; end
        chk("resume_done", 32'(done_cnt_a), 32'(d0 + 1));
        wait_idle_a(50);
        chk("sb_empty_2", 32'(sb.size()), 32'd0);

        // Reset during STOP of byte 0.
        mon_en = 1'b0;
        start_a = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (tx_a !== 1'b0 && n < 10);
        start_a = 1'b0;
        repeat (37) @(negedge clk);
        chk("in_stop", 32'(tx_a), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(tx_a), 32'd1);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        chk("rst_mid_idx", 32'(idx_a), 32'd0);
        @(negedge clk) rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1) lows++;
        end
        chk("no_partial", 32'(lows), 32'd0);
        chk("no_partial_busy", 32'(busy_a), 32'd0);

        // Repeat mode with a two bit-time gap on DUT b.
        rep_b = 1'b1;
        @(negedge clk) start_b = 1'b1;
        run = 0; started = 0; dones = 0; last_done = 0; busy_low = 0; cyc = 0;
        while (dones < 3 && cyc < 2000) begin
            @(negedge clk); cyc++;
            if (cyc == 3) start_b = 1'b0;
            if (started != 0) begin
                if (busy_b !== 1'b1) busy_low++;
                if (tx_b === 1'b1) run++;
                else begin
                    if (run > CD) chk("gap_run", 32'(run), 32'(3*CD));
                    run = 0;
                end
                if (done_b === 1'b1) begin
                    if (dones > 0) chk("done_period", 32'(cyc - last_done), 32'(ML*(FB+2)*CD));
                    last_done = cyc;
                    dones++;
                end
            end else if (tx_b === 1'b0) started = 1;
        end
        chk("repeat_dones", 32'(dones), 32'd3);
        chk("repeat_busy_held", 32'(busy_low), 32'd0);
        rep_b = 1'b0;
        n = 0;
        while (busy_b !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        chk("repeat_stop_idle", 32'(busy_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
